i2s_tx_serializer: RTL

Serializes parallel stereo PCM samples onto the I2S data line, aligned to the `bck`/`lrck` pair that `i2sclock` generates from `mclk`. It sits directly downstream of `i2sclock` and runs entirely in the `mclk` domain, treating `bck` and `lrck` as level inputs that are edge-detected. Upstream sample sources hand it one left/right pair per frame over a valid/ready handshake. It drives `sdata` to the DAC in Philips I2S format.

---
 rtl/i2s_pkg.sv | 7 +
 rtl/i2s_edge_detect.sv | 35 +++
 rtl/i2s_tx_serializer.sv | 100 ++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S types and constants for the serializer and clock generator
package i2s_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF = 6;
    localparam logic LEFT = 1'b0;
    typedef enum logic {ALIGN = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/i2s_edge_detect.sv
// i2s_edge_detect: finds bck falls and word-clock transitions in the mclk domain
module i2s_edge_detect
    import i2s_pkg::*;
(
    input  logic mclk,
    input  logic rst,
    input  logic bck,
    input  logic lrck,
    output logic bck_fall,
    output logic lr_change,
    output logic left_start
);
    logic bck_q, bck_d, lr_last_q, lr_last_d;

    assign bck_fall   = bck_q & ~bck;
    assign lr_change  = bck_fall & (lrck != lr_last_q);
    assign left_start = lr_change & (lrck == LEFT);

    // keep the previous bck level and the word clock seen at the last bck fall
    always_comb begin
        bck_d     = bck;
        lr_last_d = bck_fall ? lrck : lr_last_q;
    end

    // edge-detect registers
    always_ff @(posedge mclk) begin
        if (rst) begin
            bck_q     <= 1'b0;
            lr_last_q <= 1'b0;
        end else begin
            bck_q     <= bck_d;
            lr_last_q <= lr_last_d;
        end
    end
endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: Philips I2S transmitter fed by a valid/ready stereo sample pair
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              bck,
    input  logic              lrck,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              s_ready,
    output logic              sdata,
    output logic              locked,
    output logic              underrun
);
    localparam logic [CNT_W-1:0] BITS = CNT_W'(DATA_W);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shadow_l_q, shadow_l_d, shadow_r_q, shadow_r_d;
    logic [DATA_W-1:0] act_r_q, act_r_d, shift_q, shift_d;
    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic              shadow_full_q, shadow_full_d, sdata_q, sdata_d, underrun_q, underrun_d;
    logic              bck_fall, lr_change, left_start, run, accept, load, starve, live;

    i2s_edge_detect u_edge (
        .mclk       (mclk),
        .rst        (rst),
        .bck        (bck),
        .lrck       (lrck),
        .bck_fall   (bck_fall),
        .lr_change  (lr_change),
        .left_start (left_start)
    );

    assign run    = state_q == RUN;
    assign accept = s_valid & ~shadow_full_q;
    assign load   = left_start & shadow_full_q;
    assign starve = run & left_start & ~shadow_full_q;
    // once DATA_W bits have left the slot the register is all zero, so stop shifting
    assign live   = slot_cnt_q < BITS;

    assign s_ready  = ~shadow_full_q;
    assign locked   = run;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

    // state register
    always_ff @(posedge mclk) begin
        if (rst) state_q <= ALIGN;
        else     state_q <= state_d;
    end

    // lock onto the first left start that finds a pair waiting
    always_comb begin
        state_d = (state_q == ALIGN && load) ? RUN : state_q;
    end

    // datapath and outputs: shadow handshake, reloads and the serial shifter
    always_comb begin
        shadow_l_d    = accept ? s_left : shadow_l_q;
        shadow_r_d    = accept ? s_right : shadow_r_q;
        shadow_full_d = accept | (shadow_full_q & ~load);
        act_r_d       = load ? shadow_r_q : starve ? '0 : act_r_q;
        slot_cnt_d    = lr_change ? '0 : (bck_fall & ~&slot_cnt_q) ? slot_cnt_q + 1'b1 : slot_cnt_q;
        shift_d       = load ? shadow_l_q
                      : starve ? '0
                      : (run & lr_change) ? act_r_q
                      : (run & bck_fall & live) ? {shift_q[DATA_W-2:0], 1'b0}
                      : shift_q;
        sdata_d       = run ? (bck_fall ? shift_q[DATA_W-1] : sdata_q) : 1'b0;
        underrun_d    = starve;
    end

    // datapath registers
    always_ff @(posedge mclk) begin
        if (rst) begin
            shadow_l_q    <= '0;
            shadow_r_q    <= '0;
            shadow_full_q <= 1'b0;
            act_r_q       <= '0;
            shift_q       <= '0;
            slot_cnt_q    <= '0;
            sdata_q       <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            shadow_l_q    <= shadow_l_d;
            shadow_r_q    <= shadow_r_d;
            shadow_full_q <= shadow_full_d;
            act_r_q       <= act_r_d;
            shift_q       <= shift_d;
            slot_cnt_q    <= slot_cnt_d;
            sdata_q       <= sdata_d;
            underrun_q    <= underrun_d;
        end
    end
endmodule
